l15_mem_responder: RTL and testbench

- Responder (L1.5/memory side) of the core-to-L1.5 request/response interface used by the core memory stage.
- Accepts one request at a time: load, store, or unsupported.
- Executes the request against an internal big-endian word memory after a fixed latency.
- Returns the response with a val/req_ack handshake.
- Serves as the memory model for core-level simulation and as a small on-chip scratch memory.

---
 rtl/piton_l15_pkg.sv | 31 +++
 rtl/l15_resp_mem.sv | 28 ++
 rtl/l15_mem_responder.sv | 118 +++++++++++
 tb/tb_l15_mem_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piton_l15_pkg.sv
// piton_l15_pkg: request/return encodings, sizes, state and request types for the L1.5 responder
package piton_l15_pkg;

    localparam logic [3:0] LOAD_RQ  = 4'b0000;
    localparam logic [3:0] STORE_RQ = 4'b0001;

    localparam logic [3:0] LOAD_RET = 4'b0000;
    localparam logic [3:0] ST_ACK   = 4'b0100;
    localparam logic [3:0] INT_RET  = 4'b0111;

    localparam logic [2:0] MSG_DATA_SIZE_1B = 3'b001;
    localparam logic [2:0] MSG_DATA_SIZE_2B = 3'b010;
    localparam logic [2:0] MSG_DATA_SIZE_4B = 3'b011;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_e;

    typedef struct packed {
        logic [3:0]  rqtype;
        logic [2:0]  size;
        logic [31:0] address;
        logic [63:0] data;
    } l15_req_t;

    // a store is legal only for a supported size at its natural alignment
    function automatic logic store_aligned(input logic [2:0] size, input logic [1:0] offs);
        return (size == MSG_DATA_SIZE_1B) ||
               (size == MSG_DATA_SIZE_2B && !offs[0]) ||
               (size == MSG_DATA_SIZE_4B && offs == 2'b00);
    endfunction

endpackage

// File: rtl/l15_resp_mem.sv
// l15_resp_mem: DEPTH x 32 word RAM with big-endian byte enables and a registered 4-word line read
module l15_resp_mem #(
    parameter int DEPTH = 1024
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [3:0]                 be_i,
    input  logic [31:0]                wdata_i,
    input  logic                       re_i,
    input  logic [$clog2(DEPTH)-3:0]   rline_i,
    output logic [127:0]               rdata_o
);
    import piton_l15_pkg::*;

    logic [31:0] mem_q [DEPTH];

    // byte-masked write (be_i[3] is the lowest-addressed byte) and line read into the output register
    always_ff @(posedge clk) begin
        if (we_i)
            for (int b = 0; b < 4; b++)
                if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        if (re_i)
            rdata_o <= {mem_q[{rline_i, 2'd0}], mem_q[{rline_i, 2'd1}],
                        mem_q[{rline_i, 2'd2}], mem_q[{rline_i, 2'd3}]};
    end

endmodule

// File: rtl/l15_mem_responder.sv
// l15_mem_responder: one-at-a-time load/store responder over a big-endian word memory with fixed latency
module l15_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  core_l15_rqtype,
    input  logic [2:0]  core_l15_size,
    input  logic [31:0] core_l15_address,
    input  logic [63:0] core_l15_data,
    input  logic        core_l15_val,
    output logic        l15_core_header_ack,
    output logic        l15_core_ack,
    output logic        l15_core_val,
    output logic [3:0]  l15_core_returntype,
    output logic [63:0] l15_core_data_0,
    output logic [63:0] l15_core_data_1,
    input  logic        core_l15_req_ack,
    output logic        err_sticky
);
    import piton_l15_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    resp_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    l15_req_t      req_q, req_d;
    logic [3:0]    ret_q, ret_d;
    logic          err_q, err_d;

    logic          is_load, is_store, st_ok, commit, we, re;
    logic [63:0]   lane_data;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic [127:0]  rdata;
    logic          unused_addr;

    assign is_load  = req_q.rqtype == LOAD_RQ;
    assign is_store = req_q.rqtype == STORE_RQ;
    assign st_ok    = store_aligned(req_q.size, req_q.address[1:0]);
    assign commit   = state_q == WAIT && cnt_q == '0 && !rst;
    assign we       = commit && is_store && st_ok;
    assign re       = commit && is_load;

    // move the addressed lane to the top so every size picks its bytes from the same place
    assign lane_data = req_q.data << {req_q.address[2:0], 3'b000};
    assign wdata = req_q.size == MSG_DATA_SIZE_1B ? {4{lane_data[63:56]}} :
                   req_q.size == MSG_DATA_SIZE_2B ? {2{lane_data[63:48]}} : lane_data[63:32];
    assign be    = req_q.size == MSG_DATA_SIZE_1B ? 4'b1000 >> req_q.address[1:0] :
                   req_q.size == MSG_DATA_SIZE_2B ? (req_q.address[1] ? 4'b0011 : 4'b1100) : 4'b1111;

    assign unused_addr = ^req_q.address[31:AW+2];

    l15_resp_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (req_q.address[AW+1:2]),
        .be_i    (be),
        .wdata_i (wdata),
        .re_i    (re),
        .rline_i (req_q.address[AW+1:4]),
        .rdata_o (rdata)
    );

    // state, latency counter, latched request, return type and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            ret_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ret_q   <= ret_d;
            err_q   <= err_d;
        end
    end

    // accept in IDLE, count down in WAIT and commit on its last cycle, hold RESP until consumed
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        ret_d   = ret_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (core_l15_val) begin
                req_d   = '{rqtype: core_l15_rqtype, size: core_l15_size,
                            address: core_l15_address, data: core_l15_data};
                cnt_d   = CW'(LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: if (cnt_q == '0) begin
                ret_d   = is_load ? LOAD_RET : is_store ? ST_ACK : INT_RET;
                err_d   = err_q | (is_store ? !st_ok : !is_load);
                state_d = RESP;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            RESP: if (core_l15_req_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign l15_core_header_ack = state_q == IDLE && core_l15_val;
    assign l15_core_ack        = l15_core_header_ack;
    assign l15_core_val        = state_q == RESP;
    assign l15_core_returntype = l15_core_val ? ret_q : '0;
    assign l15_core_data_0     = (l15_core_val && ret_q == LOAD_RET) ? rdata[127:64] : '0;
    assign l15_core_data_1     = (l15_core_val && ret_q == LOAD_RET) ? rdata[63:0]   : '0;
    assign err_sticky          = err_q;

endmodule

// File: tb/tb_l15_mem_responder.sv
// tb_l15_mem_responder: randomized and directed requests checked every cycle against a behavioural model
module tb_l15_mem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk, rst;
    logic [3:0]  core_l15_rqtype;
    logic [2:0]  core_l15_size;
    logic [31:0] core_l15_address;
    logic [63:0] core_l15_data;
    logic        core_l15_val, core_l15_req_ack;
    logic        l15_core_header_ack, l15_core_ack, l15_core_val, err_sticky;
    logic [3:0]  l15_core_returntype;
    logic [63:0] l15_core_data_0, l15_core_data_1;

    l15_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .core_l15_rqtype     (core_l15_rqtype),
        .core_l15_size       (core_l15_size),
        .core_l15_address    (core_l15_address),
        .core_l15_data       (core_l15_data),
        .core_l15_val        (core_l15_val),
        .l15_core_header_ack (l15_core_header_ack),
        .l15_core_ack        (l15_core_ack),
        .l15_core_val        (l15_core_val),
        .l15_core_returntype (l15_core_returntype),
        .l15_core_data_0     (l15_core_data_0),
        .l15_core_data_1     (l15_core_data_1),
        .core_l15_req_ack    (core_l15_req_ack),
        .err_sticky          (err_sticky)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // behavioural model: byte-addressed word memory plus one outstanding request
    logic [31:0] mm [DEPTH];
    bit          chk_en = 0, pend = 0, m_err = 0, ev, eh;
    int          acc;
    logic [3:0]  lq_rq, e_ret;
    logic [2:0]  lq_sz;
    logic [31:0] lq_a;
    logic [63:0] lq_d, e_d0, e_d1;

    task automatic model_commit();
        int nb, w, b;
        e_d0 = '0;
        e_d1 = '0;
        if (lq_rq == 4'd0) begin
            e_ret = 4'd0;
            b = (int'(lq_a >> 4) * 4) % DEPTH;
            e_d0 = {mm[b], mm[b+1]};
            e_d1 = {mm[b+2], mm[b+3]};
        end else if (lq_rq == 4'd1) begin
            e_ret = 4'd4;
            nb = lq_sz == 3'd1 ? 1 : lq_sz == 3'd2 ? 2 : lq_sz == 3'd3 ? 4 : 0;
            if (nb != 0 && lq_a % nb == 0) begin
                w = int'(lq_a >> 2) % DEPTH;
                for (int k = 0; k < nb; k++)
                    mm[w][31 - 8*(int'(lq_a[1:0]) + k) -: 8] = lq_d[63 - 8*(int'(lq_a[2:0]) + k) -: 8];
            end else begin
                m_err = 1;
            end
        end else begin
            e_ret = 4'd7;
            m_err = 1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            ev = pend && cyc > acc + LAT;
            eh = !pend && core_l15_val;
            chk("header_ack", l15_core_header_ack, eh);
            chk("ack", l15_core_ack, eh);
            chk("val", l15_core_val, ev);
            chk("returntype", l15_core_returntype, ev ? e_ret : 4'd0);
            chk("data_0", l15_core_data_0, ev ? e_d0 : 64'd0);
            chk("data_1", l15_core_data_1, ev ? e_d1 : 64'd0);
            chk("err_sticky", err_sticky, m_err);
            if (rst) begin
                pend = 0;
                m_err = 0;
            end else begin
                if (ev && core_l15_req_ack) pend = 0;
                else if (pend && cyc == acc + LAT) model_commit();
                if (eh) begin
                    pend = 1;
                    acc = cyc;
                    lq_rq = core_l15_rqtype;
                    lq_sz = core_l15_size;
                    lq_a = core_l15_address;
                    lq_d = core_l15_data;
                end
            end
        end
    end

    // all driver tasks start and end 1 time unit after a rising edge
    task automatic issue(input logic [3:0] rq, input logic [2:0] sz, input logic [31:0] a,
                         input logic [63:0] d, input bit keep, output int hc);
        core_l15_rqtype = rq;
        core_l15_size = sz;
        core_l15_address = a;
        core_l15_data = d;
        core_l15_val = 1;
        hc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (l15_core_header_ack) begin
                hc = cyc;
                break;
            end
        end
        if (hc < 0) begin
            checks++;
            errors++;
            $display("FAIL header_ack_timeout: got none expected within 20 cycles");
        end
        @(posedge clk);
        #1;
        if (!keep) core_l15_val = 0;
    endtask

    task automatic wait_resp(input int dly, input bit pre, output int vc, output logic [3:0] rt,
                             output logic [63:0] d0, output logic [63:0] d1);
        if (pre) core_l15_req_ack = 1;
        vc = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (l15_core_val) begin
                vc = cyc;
                rt = l15_core_returntype;
                d0 = l15_core_data_0;
                d1 = l15_core_data_1;
                break;
            end
        end
        if (vc < 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got none expected within 30 cycles");
        end
        if (!pre) begin
            repeat (dly) @(posedge clk);
            @(posedge clk);
            #1;
            core_l15_req_ack = 1;
        end
        @(posedge clk);
        #1;
        core_l15_req_ack = 0;
    endtask

    int hc, vc, rc;
    logic [3:0]  rt, rq;
    logic [2:0]  sz;
    logic [31:0] a, old;
    logic [63:0] d0, d1, d;

    initial begin
        rst = 1;
        core_l15_val = 0;
        core_l15_req_ack = 0;
        core_l15_rqtype = 0;
        core_l15_size = 0;
        core_l15_address = 0;
        core_l15_data = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        chk_en = 1;

        for (int i = 0; i < DEPTH; i++) begin
            a = $urandom;
            issue(4'd1, 3'd3, 32'(i * 4), {a, a}, 0, hc);
            wait_resp(0, 1, vc, rt, d0, d1);
        end

        issue(4'd1, 3'd3, 32'h40, 64'hDEADBEEF_DEADBEEF, 0, hc);
        wait_resp(0, 0, vc, rt, d0, d1);
        chk("store_latency", 64'(vc - hc), 64'd3);
        chk("store_ret", rt, 4'b0100);
        issue(4'd0, 3'd3, 32'h40, 64'd0, 0, hc);
        wait_resp(1, 0, vc, rt, d0, d1);
        chk("load_word", d0[63:32], 32'hDEADBEEF);

        issue(4'd1, 3'd3, 32'h44, 64'h11223344_11223344, 0, hc);
        wait_resp(0, 0, vc, rt, d0, d1);
        issue(4'd1, 3'd1, 32'h45, 64'h0000_0000_00AA_0000, 0, hc);
        wait_resp(0, 1, vc, rt, d0, d1);
        issue(4'd0, 3'd3, 32'h40, 64'd0, 0, hc);
        wait_resp(0, 0, vc, rt, d0, d1);
        chk("byte_merge", d0[31:0], 32'h11AA3344);

        issue(4'd0, 3'd3, 32'h40, 64'd0, 1, hc);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (l15_core_val) break;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_val", l15_core_val, 1'b1);
            chk("bp_data_0", l15_core_data_0, 64'hDEADBEEF_11AA3344);
            chk("bp_hdr_ack", l15_core_header_ack, 1'b0);
        end
        @(posedge clk);
        #1;
        core_l15_req_ack = 1;
        @(negedge clk);
        chk("bp_no_ack_in_R", l15_core_header_ack, 1'b0);
        @(posedge clk);
        #1;
        core_l15_req_ack = 0;
        @(negedge clk);
        chk("bp_ack_R_plus_1", l15_core_header_ack, 1'b1);
        @(posedge clk);
        #1;
        core_l15_val = 0;
        wait_resp(0, 0, vc, rt, d0, d1);

        issue(4'd1, 3'd2, 32'h43, 64'hFFFF_FFFF_FFFF_FFFF, 0, hc);
        wait_resp(0, 0, vc, rt, d0, d1);
        chk("misalign_ret", rt, 4'b0100);
        chk("misalign_err", err_sticky, 1'b1);
        issue(4'd0, 3'd3, 32'h40, 64'd0, 0, hc);
        wait_resp(0, 0, vc, rt, d0, d1);
        chk("misalign_nowrite", d0[63:32], 32'hDEADBEEF);
        chk("err_still_set", err_sticky, 1'b1);

        issue(4'b0010, 3'd3, 32'h40, 64'h1234_5678_9ABC_DEF0, 0, hc);
        wait_resp(0, 0, vc, rt, d0, d1);
        chk("unsup_ret", rt, 4'b0111);
        chk("unsup_d0", d0, 64'd0);
        chk("unsup_d1", d1, 64'd0);
        chk("unsup_err", err_sticky, 1'b1);

        old = mm[32];
        issue(4'd1, 3'd3, 32'h80, 64'hCAFEF00D_CAFEF00D, 0, hc);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        rc = cyc;
        @(negedge clk);
        chk("rst_val", l15_core_val, 1'b0);
        chk("rst_ret", l15_core_returntype, 4'd0);
        chk("rst_err", err_sticky, 1'b0);
        @(posedge clk);
        #1;
        rc = cyc;
        issue(4'd0, 3'd3, 32'h80, 64'd0, 0, hc);
        chk("rst_idle_accept", 64'(hc), 64'(rc));
        wait_resp(0, 0, vc, rt, d0, d1);
        chk("rst_discard", d0[63:32], old);

        for (int t = 0; t < 200; t++) begin
            rc = $urandom_range(0, 99);
            rq = rc < 45 ? 4'd0 : rc < 90 ? 4'd1 : 4'($urandom_range(2, 15));
            sz = $urandom_range(0, 9) < 8 ? 3'($urandom_range(1, 3)) : 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            d = {$urandom, $urandom};
            issue(rq, sz, a, d, 0, hc);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1;
                @(posedge clk);
                #1;
                rst = 0;
            end else begin
                wait_resp($urandom_range(0, 3), $urandom_range(0, 3) == 0, vc, rt, d0, d1);
            end
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
